// File: rtl/target_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | target_scheduler : reflex-game round sequencer (target placement, delay, |
// |   reaction timing, hit/miss tally). Optional macro: TARGET_BEST_RT_EN    |
// |   adds the best_rt_ms output.                                            |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module target_scheduler #(
   parameter int unsigned CLK_PER_MS   = 25000,
   parameter int unsigned ROUNDS       = 10,
   parameter int unsigned TIMEOUT_MS   = 1000,
   parameter int unsigned MIN_DELAY_MS = 500,
   parameter int unsigned X_MAX        = 599,
   parameter int unsigned Y_MAX        = 439,
   parameter logic [9:0]  LFSR_SEED    = 10'h2A5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        frame_start,
   input  logic        hit,
   output logic [9:0]  ballX,
   output logic [9:0]  ballY,
   output logic        ball_visible,
   output logic [3:0]  hit_cnt,
   output logic [3:0]  miss_cnt,
   output logic [11:0] last_rt_ms,
   output logic        busy,
   output logic        game_done
`ifdef TARGET_BEST_RT_EN
   ,
   output logic [11:0] best_rt_ms
`endif
);

   localparam int unsigned PRESC_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [11:0] RT_MAX  = 12'hFFF;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_ARM  = 3'd2,
      S_SHOW = 3'd3,
      S_NEXT = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [9:0]         lfsr_q, lfsr_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [11:0]        ms_cnt_q, ms_cnt_d;
   logic [11:0]        delay_q, delay_d;
   logic [9:0]         shadow_x_q, shadow_x_d;
   logic [9:0]         shadow_y_q, shadow_y_d;
   logic               y_pend_q, y_pend_d;
   logic [9:0]         ball_x_q, ball_x_d;
   logic [9:0]         ball_y_q, ball_y_d;
   logic               visible_q, visible_d;
   logic [3:0]         hit_cnt_q, hit_cnt_d;
   logic [3:0]         miss_cnt_q, miss_cnt_d;
   logic [3:0]         round_q, round_d;
   logic [11:0]        last_rt_q, last_rt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
`ifdef TARGET_BEST_RT_EN
   logic [11:0]        best_rt_q, best_rt_d;
`endif

   logic [9:0]         y_raw;
   assign y_raw = {1'b0, lfsr_q[8:0]};

   always_comb begin
      state_d    = state_q;
      lfsr_d     = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
      presc_d    = presc_q;
      ms_cnt_d   = ms_cnt_q;
      delay_d    = delay_q;
      shadow_x_d = shadow_x_q;
      shadow_y_d = shadow_y_q;
      y_pend_d   = y_pend_q;
      ball_x_d   = ball_x_q;
      ball_y_d   = ball_y_q;
      visible_d  = visible_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      round_d    = round_q;
      last_rt_d  = last_rt_q;
`ifdef TARGET_BEST_RT_EN
      best_rt_d  = best_rt_q;
`endif

      // Y is sampled one clock after WAIT entry so it is decorrelated from X.
      if (state_q == S_WAIT && y_pend_q) begin
         shadow_y_d = (y_raw > 10'(Y_MAX)) ? (y_raw - 10'(Y_MAX + 1)) : y_raw;
         y_pend_d   = 1'b0;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_WAIT;
               hit_cnt_d  = 4'd0;
               miss_cnt_d = 4'd0;
               round_d    = 4'd0;
               last_rt_d  = 12'd0;
`ifdef TARGET_BEST_RT_EN
               best_rt_d  = RT_MAX;
`endif
            end
         end
         S_WAIT: begin
            if (hit) begin
               miss_cnt_d = miss_cnt_q + 4'd1;
               state_d    = S_NEXT;
            end else if (ms_cnt_q == delay_q) begin
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            if (hit) begin
               miss_cnt_d = miss_cnt_q + 4'd1;
               state_d    = S_NEXT;
            end else if (frame_start) begin
               ball_x_d  = shadow_x_q;
               ball_y_d  = shadow_y_q;
               visible_d = 1'b1;
               state_d   = S_SHOW;
            end
         end
         S_SHOW: begin
            if (hit) begin
               last_rt_d = ms_cnt_q;
               hit_cnt_d = hit_cnt_q + 4'd1;
`ifdef TARGET_BEST_RT_EN
               if (ms_cnt_q < best_rt_q) best_rt_d = ms_cnt_q;
`endif
               state_d   = S_NEXT;
            end else if (ms_cnt_q == 12'(TIMEOUT_MS)) begin
               miss_cnt_d = miss_cnt_q + 4'd1;
               state_d    = S_NEXT;
            end
         end
         S_NEXT: begin
            // Round closes on a frame boundary so the target never vanishes mid-frame.
            if (frame_start) begin
               visible_d = 1'b0;
               round_d   = round_q + 4'd1;
               state_d   = (round_d == 4'(ROUNDS)) ? S_DONE : S_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_WAIT && state_q != S_WAIT) begin
         delay_d    = 12'(MIN_DELAY_MS) + {3'b000, lfsr_q[8:0]};
         shadow_x_d = (lfsr_q > 10'(X_MAX)) ? (lfsr_q - 10'(X_MAX + 1)) : lfsr_q;
         y_pend_d   = 1'b1;
      end

      if (state_d != state_q) begin
         presc_d  = '0;
         ms_cnt_d = 12'd0;
      end else if (presc_q == PRESC_W'(CLK_PER_MS - 1)) begin
         presc_d  = '0;
         ms_cnt_d = (ms_cnt_q == RT_MAX) ? RT_MAX : ms_cnt_q + 12'd1;
      end else begin
         presc_d = presc_q + 1'b1;
      end

      busy_d = (state_d == S_WAIT) || (state_d == S_ARM) ||
               (state_d == S_SHOW) || (state_d == S_NEXT);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         lfsr_q     <= LFSR_SEED;
         presc_q    <= '0;
         ms_cnt_q   <= 12'd0;
         delay_q    <= 12'd0;
         shadow_x_q <= 10'd0;
         shadow_y_q <= 10'd0;
         y_pend_q   <= 1'b0;
         ball_x_q   <= 10'd0;
         ball_y_q   <= 10'd0;
         visible_q  <= 1'b0;
         hit_cnt_q  <= 4'd0;
         miss_cnt_q <= 4'd0;
         round_q    <= 4'd0;
         last_rt_q  <= 12'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef TARGET_BEST_RT_EN
         best_rt_q  <= RT_MAX;
`endif
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         presc_q    <= presc_d;
         ms_cnt_q   <= ms_cnt_d;
         delay_q    <= delay_d;
         shadow_x_q <= shadow_x_d;
         shadow_y_q <= shadow_y_d;
         y_pend_q   <= y_pend_d;
         ball_x_q   <= ball_x_d;
         ball_y_q   <= ball_y_d;
         visible_q  <= visible_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         round_q    <= round_d;
         last_rt_q  <= last_rt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef TARGET_BEST_RT_EN
         best_rt_q  <= best_rt_d;
`endif
      end
   end

   assign ballX        = ball_x_q;
   assign ballY        = ball_y_q;
   assign ball_visible = visible_q;
   assign hit_cnt      = hit_cnt_q;
   assign miss_cnt     = miss_cnt_q;
   assign last_rt_ms   = last_rt_q;
   assign busy         = busy_q;
   assign game_done    = done_q;
`ifdef TARGET_BEST_RT_EN
   assign best_rt_ms   = best_rt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_target_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_target_scheduler : directed, table-driven bench for target_scheduler. |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_target_scheduler;

   localparam int CPM  = 4;
   localparam int MIND = 2;
   localparam int TMO  = 8;
   localparam int RND  = 3;

   localparam int K_HIT   = 0;
   localparam int K_TMO   = 1;
   localparam int K_EARLY = 2;

   typedef struct {
      int kind;       // K_HIT / K_TMO / K_EARLY
      int k;          // SHOW cycle index on which hit is pulsed
      int exp_hit;
      int exp_miss;
      int exp_rt;
      int busy_start; // pulse start at WAIT entry (must be ignored)
   } rnd_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        frame_start = 1'b0;
   logic        hit = 1'b0;
   logic [9:0]  ballX, ballY;
   logic        ball_visible;
   logic [3:0]  hit_cnt, miss_cnt;
   logic [11:0] last_rt_ms;
   logic        busy, game_done;
`ifdef TARGET_BEST_RT_EN
   logic [11:0] best_rt_ms;
`endif

   int total = 0;
   int bad   = 0;
   int fcnt  = 0;
   logic [9:0] m_lfsr;
   logic [9:0] ent_lfsr, y_lfsr;
   rnd_t tbl [7];

   target_scheduler #(
      .CLK_PER_MS(CPM), .ROUNDS(RND), .TIMEOUT_MS(TMO), .MIN_DELAY_MS(MIND),
      .X_MAX(599), .Y_MAX(439), .LFSR_SEED(10'h2A5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .frame_start(frame_start), .hit(hit),
      .ballX(ballX), .ballY(ballY), .ball_visible(ball_visible),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .last_rt_ms(last_rt_ms),
      .busy(busy), .game_done(game_done)
`ifdef TARGET_BEST_RT_EN
      , .best_rt_ms(best_rt_ms)
`endif
   );

   always #5 clk = ~clk;

   // Reference LFSR: Fibonacci, taps 10 and 7, shifting toward the MSB.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 10'h2A5;
      else        m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
   end

   initial begin
      forever begin
         @(negedge clk);
         fcnt++;
         frame_start = (fcnt % 50 == 0);
      end
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int map_x(input logic [9:0] v);
      return (v > 10'd599) ? int'(v) - 600 : int'(v);
   endfunction

   function automatic int map_y(input logic [9:0] v);
      int y;
      y = int'(v[8:0]);
      return (y > 439) ? y - 440 : y;
   endfunction

   // Entered on WAIT cycle n0; returns at the first cycle with ball_visible high.
   task automatic wait_show(input int n0, output bit ok);
      int  n;
      int  d;
      int  f;
      bit  prev_fs;
      n       = n0;
      ok      = 1'b0;
      prev_fs = 1'b0;
      d       = MIND + int'(ent_lfsr[8:0]);
      while (n < 2400 && !ok) begin
         prev_fs = frame_start;
         tick;
         n++;
         if (ball_visible) ok = 1'b1;
      end
      check("show_reached", ok, 1);
      if (ok) begin
         f = n - 1;
         check("vis_follows_frame", prev_fs, 1);
         check("vis_not_before_delay", (f >= 4*d + 1 && f <= 4*d + 50) ? 1 : 0, 1);
         check("ballX_value", ballX, map_x(ent_lfsr));
         check("ballY_value", ballY, map_y(y_lfsr));
         check("ballX_range", (ballX <= 10'd599) ? 1 : 0, 1);
         check("ballY_range", (ballY <= 10'd439) ? 1 : 0, 1);
      end
   endtask

   // Entered in NEXT; returns on the first cycle of the following state.
   task automatic end_round(input int vis_exp);
      int cnt;
      cnt = 0;
      while (!frame_start && cnt < 60) begin
         tick;
         cnt++;
      end
      check("next_frame_seen", frame_start, 1);
      check("vis_until_frame", ball_visible, vis_exp);
      ent_lfsr = m_lfsr;
      tick;
      y_lfsr = m_lfsr;
      check("vis_cleared_at_frame", ball_visible, 0);
   endtask

   task automatic play_round(input rnd_t r, input string tag);
      bit ok;
      int n0;
      n0 = 0;
      if (r.busy_start != 0) begin
         start = 1'b1;
         tick;
         start = 1'b0;
         n0 = 1;
      end
      if (r.kind == K_EARLY) begin
         hit = 1'b1;
         tick;
         hit = 1'b0;
      end else begin
         wait_show(n0, ok);
         if (r.kind == K_HIT) begin
            repeat (r.k) tick;
            hit = 1'b1;
            tick;
            hit = 1'b0;
         end else begin
            repeat (TMO*CPM + 1) tick;
         end
      end
      check({tag, "_hit_cnt"}, hit_cnt, r.exp_hit);
      check({tag, "_miss_cnt"}, miss_cnt, r.exp_miss);
      check({tag, "_last_rt"}, last_rt_ms, r.exp_rt);
      check({tag, "_busy"}, busy, 1);
      end_round((r.kind == K_EARLY) ? 0 : 1);
   endtask

   task automatic do_start(input string tag);
      start    = 1'b1;
      ent_lfsr = m_lfsr;
      tick;
      start    = 1'b0;
      y_lfsr   = m_lfsr;
      check({tag, "_busy"}, busy, 1);
      check({tag, "_done"}, game_done, 0);
      check({tag, "_hit_clr"}, hit_cnt, 0);
      check({tag, "_miss_clr"}, miss_cnt, 0);
      check({tag, "_rt_clr"}, last_rt_ms, 0);
`ifdef TARGET_BEST_RT_EN
      check({tag, "_best_init"}, best_rt_ms, 4095);
`endif
   endtask

   initial begin
      // kind, k, hit, miss, rt, busy_start
      tbl[0] = '{K_HIT,   20, 1, 0, 5, 0};
      tbl[1] = '{K_TMO,    0, 1, 1, 5, 0};
      tbl[2] = '{K_EARLY,  0, 1, 2, 5, 0};
      tbl[3] = '{K_HIT,   32, 1, 0, 8, 0};  // hit coincides with timeout
      tbl[4] = '{K_HIT,   24, 2, 0, 6, 0};
      tbl[5] = '{K_HIT,   12, 3, 0, 3, 1};
      tbl[6] = '{K_HIT,    8, 1, 0, 2, 0};

      rst_n = 1'b0;
      repeat (3) tick;
      check("rst_ballX", ballX, 0);
      check("rst_ballY", ballY, 0);
      check("rst_visible", ball_visible, 0);
      check("rst_busy", busy, 0);
      check("rst_done", game_done, 0);
      check("rst_hit", hit_cnt, 0);
      check("rst_miss", miss_cnt, 0);
      check("rst_rt", last_rt_ms, 0);
`ifdef TARGET_BEST_RT_EN
      check("rst_best", best_rt_ms, 4095);
`endif
      rst_n = 1'b1;
      repeat (2) tick;
      hit = 1'b1;
      tick;
      hit = 1'b0;
      check("idle_hit_ignored", miss_cnt, 0);

      for (int g = 0; g < 2; g++) begin
         do_start($sformatf("g%0d_start", g));
         for (int r = 0; r < RND; r++)
            play_round(tbl[g*RND + r], $sformatf("g%0d_r%0d", g, r));
         check($sformatf("g%0d_done", g), game_done, 1);
         check($sformatf("g%0d_idle", g), busy, 0);
`ifdef TARGET_BEST_RT_EN
         check($sformatf("g%0d_best", g), best_rt_ms, (g == 0) ? 5 : 3);
`endif
         hit = 1'b1;
         tick;
         hit = 1'b0;
         check($sformatf("g%0d_done_hit_ignored", g), hit_cnt, tbl[g*RND + 2].exp_hit);
      end

      // Third game: one hit, then an asynchronous reset while the target is shown.
      begin
         bit ok;
         do_start("g2_start");
         play_round(tbl[6], "g2_r0");
         wait_show(0, ok);
         repeat (3) tick;
         #2;
         rst_n = 1'b0;
         #1;
         check("arst_ballX", ballX, 0);
         check("arst_ballY", ballY, 0);
         check("arst_visible", ball_visible, 0);
         check("arst_busy", busy, 0);
         check("arst_hit", hit_cnt, 0);
         check("arst_miss", miss_cnt, 0);
         check("arst_rt", last_rt_ms, 0);
`ifdef TARGET_BEST_RT_EN
         check("arst_best", best_rt_ms, 4095);
`endif
         tick;
         rst_n = 1'b1;
         repeat (3) tick;
         check("post_rst_busy", busy, 0);
         check("post_rst_done", game_done, 0);
         check("post_rst_visible", ball_visible, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/target_scheduler.md
Name: target_scheduler

Overview:
- Round sequencer for the reflex game.
- Picks a pseudo-random on-screen target position and holds the target hidden for a random delay, then shows it until a hit or a timeout.
- Measures reaction time in milliseconds, counts hits and misses over a fixed number of rounds, and drives the ball X/Y and visibility inputs of the pixel-compare block.
- Runs on the 25 MHz VGA clock; position updates are committed only at frame start, so a target never tears mid-frame.

Parameters:
- CLK_PER_MS, 25000, clk cycles per millisecond (benches override with a small value).
- ROUNDS, 10, rounds per game (1..15).
- TIMEOUT_MS, 1000, maximum time a target stays visible before a miss.
- MIN_DELAY_MS, 500, base hidden delay; the actual delay is MIN_DELAY_MS + lfsr[8:0] ms.
- X_MAX, 599, largest legal ballX (640 - 40 - 1).
- Y_MAX, 439, largest legal ballY (480 - 40 - 1).
- LFSR_SEED, 10'h2A5, non-zero LFSR reset value.

Ports:
- clk, in, 1, 25 MHz VGA clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle pulse; begins a game from IDLE or DONE.
- frame_start, in, 1, single-cycle pulse at the start of vertical blanking.
- hit, in, 1, single-cycle debounced player-press pulse.
- ballX, out, 10, committed target X.
- ballY, out, 10, committed target Y.
- ball_visible, out, 1, target is shown; gates the pixel-compare enable.
- hit_cnt, out, 4, hits this game.
- miss_cnt, out, 4, misses, including timeouts and early presses.
- last_rt_ms, out, 12, reaction time of the last hit, saturating at 4095.
- busy, out, 1, a game is in progress.
- game_done, out, 1, high in DONE.

Behaviour:
- rst_n low (asynchronous) clears all state:
  - State goes to IDLE and lfsr to LFSR_SEED.
  - ballX, ballY, shadow X/Y, counters, last_rt_ms, ball_visible, busy and game_done all become 0.
  - A reset asserted mid-game abandons the round with no hit or miss credited.
- lfsr: 10-bit Fibonacci, taps 10 and 7, advances every clk in every state except reset.
- Ms timebase:
  - prescaler counts 0..CLK_PER_MS-1; ms_cnt increments when the prescaler wraps.
  - Both the prescaler and ms_cnt clear on every state transition.
  - ms_cnt saturates at 4095.
- States:
  - IDLE: busy=0. start -> WAIT; clears hit_cnt, miss_cnt, last_rt_ms and the round counter.
  - WAIT, on entry:
    - Latch delay = MIN_DELAY_MS + lfsr[8:0].
    - Latch shadow X = lfsr, minus 600 if the value is greater than X_MAX.
    - Latch shadow Y = lfsr[8:0] at the next clk, minus 440 if the value is greater than Y_MAX.
  - WAIT, transitions:
    - When ms_cnt == delay -> ARM.
    - hit while in WAIT is an early press: miss_cnt+1 -> NEXT.
  - ARM:
    - Waits for frame_start; on that cycle ballX/ballY <= shadow and ball_visible <= 1 on the next edge, then -> SHOW.
    - An early press in ARM is treated as in WAIT.
  - SHOW:
    - hit -> last_rt_ms <= ms_cnt, hit_cnt+1, -> NEXT.
    - ms_cnt == TIMEOUT_MS with no hit -> miss_cnt+1 -> NEXT.
    - If hit and timeout occur on the same cycle, the hit wins.
  - NEXT:
    - ball_visible <= 0 on the next frame_start.
    - round+1; if round == ROUNDS -> DONE, else -> WAIT.
  - DONE: game_done=1, busy=0; outputs hold. start -> WAIT as from IDLE.
- start is ignored while busy.
- hit outside WAIT/ARM/SHOW is ignored.
- Counters are 4 bits and cannot overflow because ROUNDS <= 15.
- Outputs are registered. The latency from frame_start to ballX/ballY/ball_visible is 1 clk.

Optional Feature:
- Macro: TARGET_BEST_RT_EN.
- Defined:
  - Adds output best_rt_ms, 12 bits.
  - Reset and start set it to 4095.
  - On each hit it updates to min(best_rt_ms, reaction time); equal values leave it unchanged.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Bench settings: CLK_PER_MS=4, MIN_DELAY_MS=2, TIMEOUT_MS=8, ROUNDS=3, frame_start every 50 clks.
- Reset then start:
  - busy=1 the next cycle.
  - After 2+lfsr[8:0] ms, ball_visible rises exactly 1 clk after the next frame_start.
  - ballX <= 599 and ballY <= 439.
- Hit pulse 5 ms after SHOW entry -> last_rt_ms=5, hit_cnt=1, ball_visible falls on the next frame_start.
- No hit in SHOW -> after 8 ms miss_cnt=1; hit and timeout on the same cycle -> hit_cnt increments, miss_cnt does not.
- hit during WAIT -> miss_cnt=1, skips SHOW, ball_visible stays 0 for that round.
- 3 rounds complete -> game_done=1, busy=0; start -> counters cleared, busy=1; start while busy is ignored.
- rst_n low mid-SHOW -> all outputs 0 immediately, with no clk edge needed.
- With TARGET_BEST_RT_EN defined, hits of 6, 3, 5 ms -> best_rt_ms=3.
